// File: rtl/epw_tagged_alu_pkg.sv
// Shared definitions for the tagged ALU engine: opcode encoding,
// default latencies and the opcode-to-latency mapping.
package epw_tagged_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_MUL     = 3'd2,
        OP_AND     = 3'd3,
        OP_OR      = 3'd4,
        OP_XOR     = 3'd5,
        OP_SHL     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam int LAT_ALU_DEF = 2;
    localparam int LAT_MUL_DEF = 4;

    // Cycles from beat-1 accept to first valid for a given opcode.
    function automatic int lat_of(input op_e op, input int lat_alu, input int lat_mul);
        return (op == OP_MUL) ? lat_mul : lat_alu;
    endfunction

endpackage

// File: rtl/epw_tag_slot.sv
// One result slot: holds busy flag, latency countdown and stored result.
// Exposes its next-cycle busy/pending/result so the output register can
// pick a result on the same edge that makes it pending.
module epw_tag_slot #(
    parameter int RESULT_W = 16,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CNT_W-1:0]    load_cnt,
    input  logic [RESULT_W-1:0] load_res,
    input  logic                retire,
    output logic                busy,
    output logic                nxt_busy,
    output logic                nxt_pend,
    output logic [RESULT_W-1:0] nxt_res
);

    logic [CNT_W-1:0]    cnt;
    logic [RESULT_W-1:0] res;

    // Load on issue, count down toward pending, free on retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            res  <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= load_cnt;
            res  <= load_res;
        end else begin
            if (retire)
                busy <= 1'b0;
            if (busy && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // Pending means counter at zero; look one edge ahead so a result with
    // latency L reaches the registered output L cycles after issue.
    assign nxt_busy = load | (busy & ~retire);
    assign nxt_pend = load ? (load_cnt == '0) : (busy & ~retire & (cnt <= CNT_W'(1)));
    assign nxt_res  = load ? load_res : res;

endmodule

// File: rtl/epw_tagged_alu.sv
// Tagged multi-outstanding ALU: two-beat input FSM, ALU datapath,
// NUM_TAGS result slots and a lowest-tag-first registered output stage.
module epw_tagged_alu
    import epw_tagged_alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TAG_W   = 2,
    parameter int OP_W    = 3,
    parameter int LAT_ALU = LAT_ALU_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                ready,
    input  logic [OP_W-1:0]     op,
    input  logic [TAG_W-1:0]    tag,
    input  logic [DATA_W-1:0]   data,
    output logic                valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] result,
    output logic [TAG_W-1:0]    rtag,
    output logic                error
);

    localparam int RESULT_W = 2 * DATA_W;
    localparam int NUM_TAGS = 2 ** TAG_W;
    localparam int CNT_W    = $clog2(LAT_MUL + 1);
    localparam int SH_W     = $clog2(DATA_W) + 1;

    typedef enum logic {IDLE, OPND_B} state_e;

    state_e                             state, state_nxt;
    logic [OP_W-1:0]                    op_q;
    logic [TAG_W-1:0]                   tag_q;
    logic [DATA_W-1:0]                  a_q;
    logic                               accept, issue, drop, op_illegal;
    logic [RESULT_W-1:0]                a_x, b_x, alu_res;
    logic [CNT_W-1:0]                   alu_cnt;
    logic [NUM_TAGS-1:0]                load, retire, busy, nxt_busy, nxt_pend;
    logic [NUM_TAGS-1:0][RESULT_W-1:0]  nxt_res;
    logic                               sel_found;
    logic [TAG_W-1:0]                   sel_idx;

    assign accept     = in_valid & ready;
    assign issue      = accept & (state == OPND_B);
    assign op_illegal = (op_q >= OP_W'(OP_ILLEGAL));
    // Busy is the pre-edge value, so a slot retiring this cycle still collides.
    assign drop       = issue & (busy[tag_q] | op_illegal);

    // ALU datapath on the captured A and the live beat-1 B operand.
    always_comb begin
        a_x     = RESULT_W'(a_q);
        b_x     = RESULT_W'(data);
        alu_res = '0;
        case (op_e'(op_q[2:0]))
            OP_ADD:  alu_res = a_x + b_x;
            OP_SUB:  alu_res = a_x - b_x;
            OP_MUL:  alu_res = a_x * b_x;
            OP_AND:  alu_res = a_x & b_x;
            OP_OR:   alu_res = a_x | b_x;
            OP_XOR:  alu_res = a_x ^ b_x;
            OP_SHL:  alu_res = a_x << data[SH_W-1:0];
            default: alu_res = '0;
        endcase
        alu_cnt = CNT_W'(lat_of(op_e'(op_q[2:0]), LAT_ALU, LAT_MUL) - 1);
    end

    for (genvar i = 0; i < NUM_TAGS; i++) begin : g_slot
        assign load[i]   = issue & ~drop & (tag_q == TAG_W'(i));
        assign retire[i] = valid & out_ready & (rtag == TAG_W'(i));

        epw_tag_slot #(
            .RESULT_W (RESULT_W),
            .CNT_W    (CNT_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .load_cnt (alu_cnt),
            .load_res (alu_res),
            .retire   (retire[i]),
            .busy     (busy[i]),
            .nxt_busy (nxt_busy[i]),
            .nxt_pend (nxt_pend[i]),
            .nxt_res  (nxt_res[i])
        );
    end

    // Lowest-index slot that will be pending after this edge.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (nxt_pend[i]) begin
                sel_found = 1'b1;
                sel_idx   = TAG_W'(i);
            end
        end
    end

    // Input FSM next state: beat 0 then beat 1, each on a handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = OPND_B;
            OPND_B:  if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Input FSM registers: beat-0 capture, registered ready and error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_q  <= '0;
            tag_q <= '0;
            a_q   <= '0;
            ready <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            error <= drop;
            ready <= (state_nxt == OPND_B) | ~(&nxt_busy);
            if (state == IDLE && accept) begin
                op_q  <= op;
                tag_q <= tag;
                a_q   <= data;
            end
        end
    end

    // Output register: hold the presented slot until handshake, then reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid  <= 1'b0;
            result <= '0;
            rtag   <= '0;
        end else if (!valid || out_ready) begin
            valid <= sel_found;
            if (sel_found) begin
                result <= nxt_res[sel_idx];
                rtag   <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_epw_tagged_alu.sv
module tb_epw_tagged_alu;

    logic        clk, reset, in_valid, ready, valid, out_ready, error;
    logic [2:0]  op;
    logic [1:0]  tag, rtag;
    logic [7:0]  data;
    logic [15:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    epw_tagged_alu dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .ready     (ready),
        .op        (op),
        .tag       (tag),
        .data      (data),
        .valid     (valid),
        .out_ready (out_ready),
        .result    (result),
        .rtag      (rtag),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic straight from the opcode table, 16-bit result.
    function automatic logic [15:0] ref_alu(input int o, input int a, input int b);
        int r;
        case (o)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = a << (b % 16);
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic int ref_lat(input int o);
        return (o == 2) ? 4 : 2;
    endfunction

    // Present one beat and hold it until accepted; k = accept cycle.
    task automatic beat(input logic [2:0] o, input logic [1:0] t, input logic [7:0] d, output int k);
        in_valid = 1'b1; op = o; tag = t; data = d;
        for (int i = 0; i < 100 && ready !== 1'b1; i++) @(posedge clk) #1;
        k = cyc;
        if (ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL beat_timeout ready=%b required=1", ready);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] t, input logic [7:0] a, input logic [7:0] b, output int k);
        beat(o, t, a, k);
        beat(o, t, b, k);
    endtask

    task automatic wait_valid(output bit ok);
        for (int i = 0; i < 100 && valid !== 1'b1; i++) @(posedge clk) #1;
        ok = (valid === 1'b1);
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL valid_timeout valid=%b required=1", valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (ready !== 1'b0)   begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ready); end
        n_tests++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid got=%b exp=0", valid); end
        n_tests++; if (result !== 16'h0) begin n_fail++; $display("FAIL rst_result got=%h exp=0", result); end
        n_tests++; if (rtag !== 2'd0)    begin n_fail++; $display("FAIL rst_rtag got=%0d exp=0", rtag); end
        n_tests++; if (error !== 1'b0)   begin n_fail++; $display("FAIL rst_error got=%b exp=0", error); end
        reset = 1'b1;
        @(posedge clk) #1;
        n_tests++; if (ready !== 1'b1)   begin n_fail++; $display("FAIL rel_ready got=%b exp=1", ready); end
        n_tests++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL rel_valid got=%b exp=0", valid); end
    endtask

    task automatic test_add();
        int k; bit ok;
        out_ready = 1'b1;
        issue(3'd0, 2'd1, 8'h05, 8'h03, k);
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL add_error got=%b exp=0", error); end
        wait_valid(ok);
        if (ok) begin
            n_tests++; if (cyc !== k + 2)     begin n_fail++; $display("FAIL add_latency got=%0d exp=2", cyc - k); end
            n_tests++; if (result !== 16'h8) begin n_fail++; $display("FAIL add_result got=%h exp=0008", result); end
            n_tests++; if (rtag !== 2'd1)    begin n_fail++; $display("FAIL add_rtag got=%0d exp=1", rtag); end
        end
        @(posedge clk) #1;
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got=%b exp=0", valid); end
    endtask

    task automatic test_ooo();
        int k; bit ok;
        out_ready = 1'b1;
        // MUL then ADD back-to-back: both become ready in the same cycle,
        // so the lower tag (the MUL on tag 0) wins first.
        issue(3'd2, 2'd0, 8'hFF, 8'hFF, k);
        issue(3'd0, 2'd2, 8'h01, 8'h01, k);
        wait_valid(ok);
        n_tests++; if (cyc !== k + 2)       begin n_fail++; $display("FAIL ooo1_latency got=%0d exp=2", cyc - k); end
        n_tests++; if (rtag !== 2'd0 || result !== 16'hFE01) begin n_fail++; $display("FAIL ooo1_first got=%0d/%h exp=0/fe01", rtag, result); end
        @(posedge clk) #1;
        n_tests++; if (valid !== 1'b1 || rtag !== 2'd2 || result !== 16'h0002) begin n_fail++; $display("FAIL ooo1_second got=%b/%0d/%h exp=1/2/0002", valid, rtag, result); end
        @(posedge clk) #1;
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ooo1_drain got=%b exp=0", valid); end
        // MUL on tag 3 then ADD on tag 1: the later ADD returns first.
        issue(3'd2, 2'd3, 8'h12, 8'h34, k);
        issue(3'd0, 2'd1, 8'h40, 8'h40, k);
        wait_valid(ok);
        n_tests++; if (rtag !== 2'd1 || result !== 16'h0080) begin n_fail++; $display("FAIL ooo2_first got=%0d/%h exp=1/0080", rtag, result); end
        @(posedge clk) #1;
        n_tests++; if (valid !== 1'b1 || rtag !== 2'd3 || result !== 16'h03A8) begin n_fail++; $display("FAIL ooo2_second got=%b/%0d/%h exp=1/3/03a8", valid, rtag, result); end
        @(posedge clk) #1;
    endtask

    task automatic test_ops();
        int k; bit ok;
        logic [2:0] o; logic [1:0] t; logic [7:0] a, b;
        out_ready = 1'b1;
        issue(3'd1, 2'd0, 8'h00, 8'h01, k);
        wait_valid(ok);
        n_tests++; if (result !== 16'hFFFF) begin n_fail++; $display("FAIL sub_wrap got=%h exp=ffff", result); end
        @(posedge clk) #1;
        issue(3'd6, 2'd1, 8'h81, 8'h04, k);
        wait_valid(ok);
        n_tests++; if (result !== 16'h0810) begin n_fail++; $display("FAIL shl got=%h exp=0810", result); end
        @(posedge clk) #1;
        for (int i = 0; i < 10; i++) begin
            o = 3'($urandom_range(0, 6)); t = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
            issue(o, t, a, b, k);
            wait_valid(ok);
            n_tests++;
            if (cyc !== k + ref_lat(o) || rtag !== t || result !== ref_alu(o, a, b)) begin
                n_fail++;
                $display("FAIL rand_op op=%0d a=%h b=%h got=%h/tag%0d/lat%0d exp=%h/tag%0d/lat%0d",
                         o, a, b, result, rtag, cyc - k, ref_alu(o, a, b), t, ref_lat(o));
            end
            @(posedge clk) #1;
        end
    endtask

    task automatic test_errors();
        int k; bit ok, seen;
        out_ready = 1'b0;
        issue(3'd0, 2'd3, 8'h07, 8'h09, k);
        wait_valid(ok);
        issue(3'd1, 2'd3, 8'h01, 8'h01, k);
        n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL busy_drop_err got=%b exp=1", error); end
        @(posedge clk) #1;
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got=%b exp=0", error); end
        issue(3'd7, 2'd1, 8'h02, 8'h02, k);
        n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL illegal_err got=%b exp=1", error); end
        n_tests++; if (valid !== 1'b1 || rtag !== 2'd3 || result !== 16'h0010) begin n_fail++; $display("FAIL tag3_intact got=%b/%0d/%h exp=1/3/0010", valid, rtag, result); end
        out_ready = 1'b1;
        @(posedge clk) #1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (valid !== 1'b0 || error !== 1'b0) seen = 1'b1;
            @(posedge clk) #1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL dropped_no_result got=seen exp=none"); end
    endtask

    task automatic test_full();
        int k;
        logic [15:0] ex [4];
        ex[0] = 16'h0100; ex[1] = 16'h0003; ex[2] = 16'h00FF; ex[3] = 16'h005A;
        out_ready = 1'b0;
        issue(3'd2, 2'd0, 8'h10, 8'h10, k);
        issue(3'd0, 2'd1, 8'h01, 8'h02, k);
        issue(3'd5, 2'd2, 8'hF0, 8'h0F, k);
        issue(3'd4, 2'd3, 8'h0A, 8'h50, k);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", ready); end
        repeat (5) @(posedge clk) #1;
        n_tests++; if (ready !== 1'b0 || valid !== 1'b1 || rtag !== 2'd0) begin n_fail++; $display("FAIL full_hold got=%b/%b/%0d exp=0/1/0", ready, valid, rtag); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (valid !== 1'b1 || rtag !== 2'(i) || result !== ex[i]) begin
                n_fail++; $display("FAIL full_order%0d got=%b/%0d/%h exp=1/%0d/%h", i, valid, rtag, result, i, ex[i]);
            end
            @(posedge clk) #1;
            if (i == 0) begin
                n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise got=%b exp=1", ready); end
            end
        end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL full_drain got=%b exp=0", valid); end
    endtask

    task automatic test_reset_mid();
        int k; bit ok, seen;
        out_ready = 1'b0;
        issue(3'd0, 2'd0, 8'h01, 8'h01, k);
        issue(3'd0, 2'd1, 8'h02, 8'h02, k);
        issue(3'd0, 2'd2, 8'h03, 8'h03, k);
        repeat (3) @(posedge clk) #1;
        beat(3'd0, 2'd3, 8'h11, k);
        #2 reset = 1'b0;
        #1;
        n_tests++; if (valid !== 1'b0 || ready !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL midrst_async got=%b/%b/%b exp=0/0/0", valid, ready, error); end
        @(posedge clk);
        @(posedge clk) #1;
        reset = 1'b1;
        @(posedge clk) #1;
        n_tests++; if (ready !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL midrst_release got=%b/%b exp=1/0", ready, valid); end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (valid !== 1'b0 || error !== 1'b0) seen = 1'b1;
            @(posedge clk) #1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL midrst_stale got=seen exp=none"); end
        issue(3'd0, 2'd2, 8'h20, 8'h22, k);
        wait_valid(ok);
        n_tests++; if (cyc !== k + 2 || rtag !== 2'd2 || result !== 16'h0042) begin n_fail++; $display("FAIL midrst_fresh got=%0d/%0d/%h exp=2/2/0042", cyc - k, rtag, result); end
        @(posedge clk) #1;
    endtask

    // Cycle-level random traffic against a slot/arbitration model.
    task automatic test_random();
        bit          busy_m [4];
        logic [15:0] exp_m  [4];
        int          avail_m[4];
        bit beat1, err_exp, pres_v, hs, any_free, exp_ready, iss, draining, none;
        int op_c, tag_c, a_c, pres_t;
        beat1 = 0; err_exp = 0; pres_v = 0; hs = 0; op_c = 0; tag_c = 0; a_c = 0; pres_t = 0;
        for (int t = 0; t < 4; t++) begin busy_m[t] = 0; exp_m[t] = '0; avail_m[t] = 0; end
        for (int c = 0; c < 800; c++) begin
            draining = (c >= 600);
            none = 1'b1;
            for (int t = 0; t < 4; t++) if (busy_m[t]) none = 1'b0;
            if (draining && none && !beat1 && !err_exp && !pres_v) break;
            if (!pres_v || hs) begin
                pres_v = 1'b0;
                for (int t = 3; t >= 0; t--)
                    if (busy_m[t] && cyc >= avail_m[t]) begin pres_v = 1'b1; pres_t = t; end
            end
            any_free = !none || 1'b0;
            any_free = 1'b0;
            for (int t = 0; t < 4; t++) if (!busy_m[t]) any_free = 1'b1;
            exp_ready = beat1 | any_free;
            n_tests++; if (error !== err_exp)   begin n_fail++; $display("FAIL rnd_error cyc=%0d got=%b exp=%b", cyc, error, err_exp); end
            n_tests++; if (ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ready, exp_ready); end
            n_tests++; if (valid !== pres_v)    begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid, pres_v); end
            if (pres_v) begin
                n_tests++;
                if (rtag !== 2'(pres_t) || result !== exp_m[pres_t]) begin
                    n_fail++; $display("FAIL rnd_result cyc=%0d got=%0d/%h exp=%0d/%h", cyc, rtag, result, pres_t, exp_m[pres_t]);
                end
            end
            out_ready = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid  = draining ? beat1 : ($urandom_range(0, 3) != 0);
            op   = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            tag  = 2'($urandom);
            data = 8'($urandom);
            hs = pres_v && out_ready;
            iss = 1'b0; err_exp = 1'b0;
            if (in_valid && exp_ready) begin
                if (!beat1) begin
                    op_c = int'(op); tag_c = int'(tag); a_c = int'(data); beat1 = 1'b1;
                end else begin
                    beat1 = 1'b0;
                    if (busy_m[tag_c] || op_c == 7) err_exp = 1'b1;
                    else iss = 1'b1;
                end
            end
            if (hs) busy_m[pres_t] = 1'b0;
            if (iss) begin
                busy_m[tag_c]  = 1'b1;
                exp_m[tag_c]   = ref_alu(op_c, a_c, int'(data));
                avail_m[tag_c] = cyc + ref_lat(op_c);
            end
            @(posedge clk) #1;
        end
        in_valid = 1'b0;
        none = 1'b1;
        for (int t = 0; t < 4; t++) if (busy_m[t]) none = 1'b0;
        n_tests++; if (!none) begin n_fail++; $display("FAIL rnd_lost got=outstanding exp=drained"); end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; op = '0; tag = '0; data = '0; out_ready = 1'b0;
        test_reset();
        test_add();
        test_ooo();
        test_ops();
        test_errors();
        test_full();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
